// File: rtl/measure_pkg.sv
// Shared types and defaults for the encoder measurement run controller.
package measure_pkg;

   localparam int RESR_PER_GROUP_DEF = 16;
   localparam int GROUP_NUM_DEF      = 10;
   localparam int CNT_W_DEF          = 16;

   // Width of a group index; never below one bit so a single-group run still has a field.
   function automatic int grp_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int GRP_W_DEF = grp_width(GROUP_NUM_DEF);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_ZERO = 2'd1,
      ST_GROUP     = 2'd2
   } seq_state_t;

   // Result record layout for the default configuration; the sequencer packs the
   // same fields, in the same order, sized from its own parameters.
   typedef struct packed {
      logic [GRP_W_DEF-1:0] group;
      logic [CNT_W_DEF-1:0] phase;
      logic [CNT_W_DEF-1:0] rgs_cnt;
      logic                 missing;
   } meas_result_t;

endpackage

// File: rtl/measure_result_reg.sv
// Single-entry valid/ready holding register. A new record offered while the
// held one is still waiting is dropped and reported on a one-cycle overrun strobe.
module measure_result_reg
   import measure_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         offer,
   input  logic [W-1:0] offer_data,
   input  logic         ready,
   output logic         valid,
   output logic [W-1:0] data,
   output logic         overrun
);

   logic         valid_r;
   logic [W-1:0] data_r;
   logic         valid_n;
   logic [W-1:0] data_n;
   logic         overrun_s;

   // Next-state of the holding register: clear, load, drop or drain.
   always_comb begin
      valid_n   = valid_r;
      data_n    = data_r;
      overrun_s = 1'b0;
      if (clr) begin
         valid_n = 1'b0;
      end else if (offer) begin
         if (valid_r && !ready) begin
            overrun_s = 1'b1;
         end else begin
            valid_n = 1'b1;
            data_n  = offer_data;
         end
      end else if (valid_r && ready) begin
         valid_n = 1'b0;
      end else begin
         valid_n = valid_r;
      end
   end

   // Holding register state.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r <= 1'b0;
         data_r  <= '0;
      end else begin
         valid_r <= valid_n;
         data_r  <= data_n;
      end
   end

   assign valid   = valid_r;
   assign data    = data_r;
   assign overrun = overrun_s;

endmodule

// File: rtl/measure_sequencer.sv
// Run controller: arms on the zero marker after start, splits the revolution
// into groups of RESR pulses and emits one phase/count record per group.
module measure_sequencer
   import measure_pkg::*;
#(
   parameter int RESR_PER_GROUP = RESR_PER_GROUP_DEF,
   parameter int GROUP_NUM      = GROUP_NUM_DEF,
   parameter int CNT_W          = CNT_W_DEF
) (
   input  logic                              CLOCK_50M,
   input  logic                              RST,
   input  logic                              start,
   input  logic                              abort,
   input  logic                              iRESR_signalA,
   input  logic                              iRESR_signalZ,
   input  logic                              iRGS_signalA,
   output logic                              busy,
   output logic                              done,
   output logic                              res_valid,
   input  logic                              res_ready,
   output logic [grp_width(GROUP_NUM)-1:0]   res_group,
   output logic [CNT_W-1:0]                  res_phase,
   output logic [CNT_W-1:0]                  res_rgs_cnt,
   output logic                              res_missing,
   output logic                              err_overrun,
   output logic                              err_zero_early
);

   localparam int GRP_W = grp_width(GROUP_NUM);
   localparam int REC_W = GRP_W + 2 * CNT_W + 1;

   seq_state_t       state_r, state_n;
   logic [GRP_W-1:0] grp_r, grp_n, base_grp_s;
   logic [CNT_W-1:0] resr_cnt_r, resr_n, base_resr_s;
   logic [CNT_W-1:0] rgs_cnt_r, rgs_n, base_rgs_s;
   logic [CNT_W-1:0] phase_r, phase_n, base_phase_s;
   logic             first_seen_r, first_n, base_first_s;
   logic             busy_r, done_r, done_n;
   logic             err_zero_early_r, zerr_n;
   logic             err_overrun_r;
   logic             arm_s, count_s, close_s, offer_s, overrun_s, start_ok_s;
   logic [REC_W-1:0] rec_s, res_data_s;

   // RGS counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}}) begin
         return v;
      end else begin
         return v + CNT_W'(1);
      end
   endfunction

   assign start_ok_s = (state_r == ST_IDLE) && start && !abort;

   // Sequencer next state: FSM, group counters and record assembly.
   always_comb begin
      state_n      = state_r;
      grp_n        = grp_r;
      resr_n       = resr_cnt_r;
      rgs_n        = rgs_cnt_r;
      first_n      = first_seen_r;
      phase_n      = phase_r;
      done_n       = 1'b0;
      zerr_n       = err_zero_early_r;
      arm_s        = 1'b0;
      count_s      = 1'b0;
      close_s      = 1'b0;
      offer_s      = 1'b0;
      rec_s        = '0;
      base_grp_s   = grp_r;
      base_resr_s  = resr_cnt_r;
      base_rgs_s   = rgs_cnt_r;
      base_phase_s = phase_r;
      base_first_s = first_seen_r;
      if (abort) begin
         state_n = ST_IDLE;
         grp_n   = '0;
         resr_n  = '0;
         rgs_n   = '0;
         first_n = 1'b0;
         phase_n = '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  state_n = ST_WAIT_ZERO;
                  zerr_n  = 1'b0;
               end else begin
                  state_n = ST_IDLE;
               end
            end
            ST_WAIT_ZERO: begin
               if (iRESR_signalZ) begin
                  state_n = ST_GROUP;
                  arm_s   = 1'b1;
               end else begin
                  state_n = ST_WAIT_ZERO;
               end
            end
            ST_GROUP: begin
               count_s = 1'b1;
               if (iRESR_signalZ) begin
                  // Early zero marker: drop the partial group and restart at group 0.
                  arm_s  = 1'b1;
                  zerr_n = 1'b1;
               end else begin
                  close_s = iRESR_signalA &&
                            (resr_cnt_r == CNT_W'(RESR_PER_GROUP - 1));
               end
            end
            default: begin
               state_n = ST_IDLE;
            end
         endcase

         // Arming starts from cleared counters; same-cycle pulses still count.
         if (arm_s) begin
            base_grp_s   = '0;
            base_resr_s  = '0;
            base_rgs_s   = '0;
            base_phase_s = '0;
            base_first_s = 1'b0;
         end else begin
            base_grp_s   = grp_r;
            base_resr_s  = resr_cnt_r;
            base_rgs_s   = rgs_cnt_r;
            base_phase_s = phase_r;
            base_first_s = first_seen_r;
         end

         if (arm_s || count_s) begin
            grp_n  = base_grp_s;
            resr_n = base_resr_s + CNT_W'(iRESR_signalA);
            if (iRGS_signalA) begin
               rgs_n   = sat_inc(base_rgs_s);
               first_n = 1'b1;
               if (base_first_s) begin
                  phase_n = base_phase_s;
               end else begin
                  phase_n = base_resr_s + CNT_W'(iRESR_signalA);
               end
            end else begin
               rgs_n   = base_rgs_s;
               first_n = base_first_s;
               phase_n = base_phase_s;
            end
            if (close_s) begin
               // Closing A: the record includes any same-cycle RGS pulse.
               offer_s = 1'b1;
               rec_s   = {grp_r, phase_n, rgs_n, ~first_n};
               resr_n  = '0;
               rgs_n   = '0;
               phase_n = '0;
               first_n = 1'b0;
               if (grp_r == GRP_W'(GROUP_NUM - 1)) begin
                  state_n = ST_IDLE;
                  done_n  = 1'b1;
                  grp_n   = '0;
               end else begin
                  grp_n   = grp_r + GRP_W'(1);
               end
            end else begin
               offer_s = 1'b0;
            end
         end else begin
            grp_n = grp_r;
         end
      end
   end

   // Sequencer state, counters and registered status outputs.
   always_ff @(posedge CLOCK_50M) begin
      if (RST) begin
         state_r          <= ST_IDLE;
         grp_r            <= '0;
         resr_cnt_r       <= '0;
         rgs_cnt_r        <= '0;
         phase_r          <= '0;
         first_seen_r     <= 1'b0;
         busy_r           <= 1'b0;
         done_r           <= 1'b0;
         err_zero_early_r <= 1'b0;
      end else begin
         state_r          <= state_n;
         grp_r            <= grp_n;
         resr_cnt_r       <= resr_n;
         rgs_cnt_r        <= rgs_n;
         phase_r          <= phase_n;
         first_seen_r     <= first_n;
         busy_r           <= (state_n != ST_IDLE);
         done_r           <= done_n;
         err_zero_early_r <= zerr_n;
      end
   end

   // Overrun flag: sticky until reset or an accepted start.
   always_ff @(posedge CLOCK_50M) begin
      if (RST) begin
         err_overrun_r <= 1'b0;
      end else if (start_ok_s) begin
         err_overrun_r <= 1'b0;
      end else begin
         err_overrun_r <= err_overrun_r | overrun_s;
      end
   end

   measure_result_reg #(
      .W (REC_W)
   ) u_result (
      .clk        (CLOCK_50M),
      .rst        (RST),
      .clr        (abort),
      .offer      (offer_s),
      .offer_data (rec_s),
      .ready      (res_ready),
      .valid      (res_valid),
      .data       (res_data_s),
      .overrun    (overrun_s)
   );

   assign {res_group, res_phase, res_rgs_cnt, res_missing} = res_data_s;
   assign busy           = busy_r;
   assign done           = done_r;
   assign err_overrun    = err_overrun_r;
   assign err_zero_early = err_zero_early_r;

endmodule

// File: doc/measure_sequencer.md
# measure_sequencer

Run controller for the encoder measurement datapath. On a `start` command it arms on the next zero-marker pulse. It then splits the following revolution into `GROUP_NUM` groups of `RESR_PER_GROUP` RESR pulses. For each group it records the RESR phase at the first RGS pulse and the RGS pulse count, and hands one result record per group to a downstream reader over a valid/ready interface.

## Interface
Parameters:
- `RESR_PER_GROUP`, 16: RESR pulses per group (≥2).
- `GROUP_NUM`, 10: groups per run (≥1).
- `CNT_W`, 16: counter and result field width.

Ports:
- `CLOCK_50M` in 1: sole clock.
- `RST` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle run request; ignored while `busy`.
- `abort` in 1: one-cycle cancel; highest priority.
- `iRESR_signalA` in 1: one-cycle RESR pulse, already synchronous.
- `iRESR_signalZ` in 1: one-cycle zero-marker pulse.
- `iRGS_signalA` in 1: one-cycle RGS pulse.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse when a run completes.
- `res_valid` out 1: result record available.
- `res_ready` in 1: reader accepts the record.
- `res_group` out clog2(GROUP_NUM): group index, 0..GROUP_NUM-1.
- `res_phase` out CNT_W: RESR count at the first RGS pulse.
- `res_rgs_cnt` out CNT_W: RGS pulses in the group.
- `res_missing` out 1: no RGS pulse in the group (`res_phase`=0).
- `err_overrun` out 1: sticky; a record was dropped.
- `err_zero_early` out 1: sticky; Z arrived mid-run.

## Operation
- States: IDLE, WAIT_ZERO, GROUP.
  - IDLE + `start` → WAIT_ZERO.
  - WAIT_ZERO + Z → GROUP.
  - GROUP + close of group `GROUP_NUM-1` → IDLE, with `done`.
- Entering GROUP clears `grp`, `resr_cnt`, `rgs_cnt` and `first_seen`. An A or RGS pulse in the same cycle as the arming Z counts toward group 0.
- In GROUP:
  - A: `resr_cnt`+1.
  - RGS: `rgs_cnt`+1, saturating at all-ones.
  - First RGS in a group: capture `phase = resr_cnt + A`, where A is the same-cycle A pulse; set `first_seen`.
- Group close: an A pulse with `resr_cnt==RESR_PER_GROUP-1`.
  - Same-cycle RGS belongs to the closing group.
  - Record `{grp, phase, rgs_cnt, !first_seen}` is offered to the result register.
  - Counters reset to 0, `grp`+1; counting continues with no dead cycle.
- Z in GROUP: set `err_zero_early`, discard the partial group, resync to group 0 as in the arming cycle. Records already emitted stand.
- `abort`: → IDLE, clear `res_valid`, no `done`. Sticky errors are kept.
- Result register, single entry:
  - Offer while `res_valid && !res_ready`: drop the new record, set `err_overrun`.
  - Offer in the same cycle as a transfer: load the new record, no error.
- Sticky errors clear only on `RST` or an accepted `start`.
- `RST`: state IDLE. All outputs 0, including `res_*`, `busy`, `done` and the errors; all counters 0.

## Timing
- `busy` rises the cycle after `start`.
- `res_valid` rises the cycle after the closing A. It holds with stable fields until a `res_valid && res_ready` cycle.
- `done` pulses the cycle after the last closing A, coincident with that group's `res_valid`. `busy` falls in the same cycle.
- `abort` or `RST` takes effect at the next edge; any in-flight group is lost.
- `start` and `abort` in the same cycle: `abort` wins, stay IDLE.

## Structure
- Package `measure_pkg`:
  - state enum `seq_state_t`.
  - record typedef `meas_result_t` (group, phase, rgs_cnt, missing).
  - default constants `RESR_PER_GROUP_DEF`, `GROUP_NUM_DEF`.
- Sub-module `measure_result_reg`: single-entry valid/ready holding register with drop-on-full and an overrun strobe.
- Everything else (FSM, counters) lives in `measure_sequencer`.

## Test plan
- A every 5 cycles, RGS every 16 cycles, Z at cycle 100, `start` at cycle 20 → 10 records, `res_group` 0..9, each `res_missing`=0, `done` with record 9, no errors.
- RGS pulse coincident with the 16th A of group 0 → record 0: `res_phase`=16, and the RGS is counted in group 0, not group 1.
- `res_ready` held 0 from group 0 onward → record 0 held stable; group 1 close sets `err_overrun`, record 1 dropped; raising ready yields record 0 then record 2.
- RGS disabled → every record `res_missing`=1, `res_phase`=0, `res_rgs_cnt`=0.
- Z injected after 7 A pulses in group 3 → `err_zero_early`=1, next record `res_group`=0.
- `abort` during group 4, then `RST` mid-run → IDLE, `res_valid`=0, no `done`; all outputs 0 after reset.
